// File: rtl/rc4_pkg.sv
// Shared RC4 types: state encodings for the key scheduler and the PRGA decryptor,
// plus the S-RAM geometry constants.
package rc4_pkg;

   localparam int KEY_LEN_DEFAULT = 3;
   localparam int S_DEPTH         = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      KSA_IDLE,
      KSA_FILL,
      KSA_ADDR_I,
      KSA_RD_SI,
      KSA_RD_SJ,
      KSA_WR_I,
      KSA_WR_J,
      KSA_DONE
   } ksa_state_t;

   typedef enum logic [3:0] {
      PRGA_IDLE,
      PRGA_ADDR_I,
      PRGA_RD_SI,
      PRGA_RD_SJ,
      PRGA_WR_I,
      PRGA_WR_J,
      PRGA_ADDR_F,
      PRGA_RD_F,
      PRGA_OUT,
      PRGA_DONE
   } prga_state_t;

endpackage

// File: rtl/ksa_shuffler_if.sv
// Control + S-RAM port bundle of the key scheduler. slave = the shuffler,
// master = the controller / S-RAM mux side.
interface ksa_shuffler_if #(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_LENGTH = 8,
   parameter int KEY_LEN    = 3
) ();
   logic                    start;
   logic [8*KEY_LEN-1:0]    key;
   logic [RAM_WIDTH-1:0]    sOut;
   logic [RAM_WIDTH-1:0]    sIn;
   logic [RAM_LENGTH-1:0]   sAddr;
   logic                    sWren;
   logic                    busy;
   logic                    finished;

   modport slave (
      input  start, key, sOut,
      output sIn, sAddr, sWren, busy, finished
   );

   modport master (
      output start, key, sOut,
      input  sIn, sAddr, sWren, busy, finished
   );
endinterface

// File: rtl/ksa_shuffler_key_byte_sel.sv
// Picks byte kidx of the captured key, byte 0 being the most significant.
module key_byte_sel
   import rc4_pkg::*;
#(
   parameter int KEY_LEN = KEY_LEN_DEFAULT,
   parameter int KIDX_W  = 2
) (
   input  logic [8*KEY_LEN-1:0] key_i,
   input  logic [KIDX_W-1:0]    kidx_i,
   output byte_t                byte_o
);
   always_comb begin
      byte_o = '0;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (kidx_i == KIDX_W'(k)) byte_o = key_i[8*(KEY_LEN-1-k) +: 8];
      end
   end
endmodule

// File: rtl/ksa_shuffler.sv
// RC4 key-scheduling shuffler over the shared S-RAM (1-cycle read latency).
// Define KSA_INIT_FILL_EN to write the identity permutation into S before shuffling.
module ksa_shuffler
   import rc4_pkg::*;
#(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_LENGTH = 8,
   parameter int KEY_LEN    = KEY_LEN_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   ksa_shuffler_if.slave  bus
);
   localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
   localparam logic [RAM_LENGTH-1:0] I_LAST    = '1;
   localparam logic [KIDX_W-1:0]     KIDX_LAST = KIDX_W'(KEY_LEN-1);

   ksa_state_t             state_q, state_d;
   logic [RAM_LENGTH-1:0]  i_q, i_d, j_q, j_d;
   logic [KIDX_W-1:0]      kidx_q, kidx_d;
   logic [RAM_WIDTH-1:0]   si_q, si_d, sj_q, sj_d;
   logic [8*KEY_LEN-1:0]   key_q, key_d;

   byte_t                  kbyte;
   logic [RAM_LENGTH-1:0]  jn;

   key_byte_sel #(.KEY_LEN(KEY_LEN), .KIDX_W(KIDX_W)) u_ksel (
      .key_i  (key_q),
      .kidx_i (kidx_q),
      .byte_o (kbyte)
   );

   // New j; only meaningful in RD_SI, where sOut carries S[i].
   assign jn = j_q + RAM_LENGTH'(bus.sOut) + RAM_LENGTH'(kbyte);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= KSA_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      kidx_d  = kidx_q;
      si_d    = si_q;
      sj_d    = sj_q;
      key_d   = key_q;
      case (state_q)
         KSA_IDLE: begin
            if (bus.start) begin
               key_d  = bus.key;
               i_d    = '0;
               j_d    = '0;
               kidx_d = '0;
`ifdef KSA_INIT_FILL_EN
               state_d = KSA_FILL;
`else
               state_d = KSA_ADDR_I;
`endif
            end
         end
`ifdef KSA_INIT_FILL_EN
         KSA_FILL: begin
            i_d = i_q + 1'b1;
            if (i_q == I_LAST) state_d = KSA_ADDR_I;
         end
`endif
         KSA_ADDR_I: state_d = KSA_RD_SI;
         KSA_RD_SI: begin
            si_d    = bus.sOut;
            j_d     = jn;
            state_d = KSA_RD_SJ;
         end
         KSA_RD_SJ: begin
            sj_d    = bus.sOut;
            state_d = KSA_WR_I;
         end
         KSA_WR_I: state_d = KSA_WR_J;
         KSA_WR_J: begin
            if (i_q == I_LAST) begin
               state_d = KSA_DONE;
            end else begin
               i_d     = i_q + 1'b1;
               kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
               state_d = KSA_ADDR_I;
            end
         end
         KSA_DONE: state_d = KSA_IDLE;
         default:  state_d = KSA_IDLE;
      endcase
   end

   always_comb begin
      bus.sIn      = '0;
      bus.sAddr    = '0;
      bus.sWren    = 1'b0;
      bus.finished = 1'b0;
      bus.busy     = (state_q != KSA_IDLE);
      case (state_q)
`ifdef KSA_INIT_FILL_EN
         KSA_FILL: begin
            bus.sAddr = i_q;
            bus.sIn   = RAM_WIDTH'(i_q);
            bus.sWren = 1'b1;
         end
`endif
         KSA_ADDR_I: bus.sAddr = i_q;
         KSA_RD_SI:  bus.sAddr = jn;
         KSA_RD_SJ:  bus.sAddr = j_q;
         KSA_WR_I: begin
            bus.sAddr = i_q;
            bus.sIn   = sj_q;
            bus.sWren = 1'b1;
         end
         KSA_WR_J: begin
            bus.sAddr = j_q;
            bus.sIn   = si_q;
            bus.sWren = 1'b1;
         end
         KSA_DONE: bus.finished = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: doc/ksa_shuffler.md
Name: ksa_shuffler

Overview:
- Upstream RC4 stage: runs the key-scheduling algorithm on the shared 256-entry S working RAM before the PRGA decryptor runs.
- Optionally fills S with the identity permutation, then performs 256 swap iterations driven by the secret key.
- Its `finished` pulse is the decryptor's `start`. It shares the S-RAM port through the top-level mux, which selects this block while `busy` is high.

Parameters:
- RAM_WIDTH, 8, S-RAM data width (bits per byte of state).
- RAM_LENGTH, 8, S-RAM address width (256 entries).
- KEY_LEN, 3, secret-key length in bytes.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- key  input  8*KEY_LEN  secret key; byte 0 = key[8*KEY_LEN-1 -: 8] (MSB first); captured when start is accepted.
- sOut  input  RAM_WIDTH  S-RAM read data, valid one cycle after sAddr is presented.
- sIn  output  RAM_WIDTH  S-RAM write data.
- sAddr  output  RAM_LENGTH  S-RAM address.
- sWren  output  1  S-RAM write enable.
- busy  output  1  high in every state except IDLE.
- finished  output  1  one-cycle pulse on completion.

Behaviour:
- Reset: state=IDLE. Registers i, j, kidx, si, sj, key_q all cleared. Outputs sIn=0, sAddr=0, sWren=0, busy=0, finished=0.
- Reset mid-operation aborts immediately to IDLE. S-RAM contents are then undefined and no finished pulse is issued.

States:
- IDLE: if start, capture key_q, clear i/j/kidx, go to FILL (or ADDR_I when fill is compiled out).
- FILL: sAddr=i, sIn=i, sWren=1, i++. When i==255, go to ADDR_I with i wrapped to 0.
- ADDR_I: sAddr=i. Go to RD_SI.
- RD_SI:
  - si<=sOut.
  - jn = j + sOut + key_q byte[kidx], mod 2^RAM_LENGTH (8-bit wrap, carries dropped).
  - j<=jn; sAddr=jn. Go to RD_SJ.
- RD_SJ: sj<=sOut; sAddr=j. Go to WR_I.
- WR_I: sAddr=i, sIn=sj, sWren=1. Go to WR_J.
- WR_J:
  - sAddr=j, sIn=si, sWren=1.
  - If i==255, go to DONE.
  - Else i++, kidx = (kidx==KEY_LEN-1) ? 0 : kidx+1, go to ADDR_I.
- DONE: finished=1, busy=1. Go to IDLE.

Rules:
- kidx is a wrap counter standing in for i mod KEY_LEN; no divider is used.
- In non-write states sIn=0 and sWren=0.
- i==j: both writes hit the same address with the same value, so the permutation is preserved. No special case is needed.
- Latency: start is sampled high in IDLE at cycle N; finished is high at cycle N+1537 (N+1281 with fill compiled out). Each iteration takes 5 cycles.
- start held high through DONE re-triggers at the IDLE visit after DONE. start while busy is ignored. Changes to key while busy have no effect.

Optional Feature:
- Macro: KSA_INIT_FILL_EN.
- Defined: the FILL state exists and S is written with s[k]=k before shuffling.
- Undefined:
  - FILL is removed and IDLE goes straight to ADDR_I; S must be preloaded by a separate init block.
  - First S-RAM write occurs at WR_I of iteration 0.

Decomposition:
- Package rc4_pkg holds:
  - ksa_state_t enum;
  - KEY_LEN_DEFAULT=3;
  - byte_t typedef (logic [7:0]);
  - S_DEPTH=256;
  - the state types shared with the decryptor.
- Sub-module key_byte_sel: combinational mux returning byte kidx of key_q (MSB-first), parameterised by KEY_LEN.

Test Plan:
- Fill, key=24'h000000: reset, start pulse → 256 writes with addr k, data k in cycles N+1..N+256; first write addr 0 data 0; finished at N+1537.
- First swaps, key=24'h000000:
  - Iterations 0 and 1 write addr0←0 twice, then addr1←1 twice.
  - Iteration 2 writes addr2←3 then addr3←2.
  - Iteration 3 writes addr3←5 then addr5←2.
- Golden compare, key=24'h000249: final RAM image equals the software KSA model byte-for-byte. Then chain to the decryptor and check its success=1 on the reference ciphertext.
- Reset mid-shuffle: assert reset at N+600 → next cycle busy=0, sWren=0, state IDLE, no finished pulse. A fresh start completes with the correct image.
- start during busy: pulse start at N+100 and N+900 → ignored, finished exactly once at N+1537. start held high → second run starts at N+1538, finished again at N+3075.
- Fill compiled out (no KSA_INIT_FILL_EN), RAM preloaded with identity, key=24'h000000 → first write at N+4 (addr0←0), finished at N+1281, same final image as with the fill.
